alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: RA_W, 5, register-address width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high; ports are clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 stall  in  1  hold stage contents.
REQ-007 flush  in  1  replace stage contents with bubble.
REQ-008 id_valid  in  1  ID-stage instruction valid.
REQ-009 id_rs_data, id_rt_data  in  DATA_W  register-file read data.
REQ-010 id_rs, id_rt, id_rd  in  RA_W  source/destination addresses.
REQ-011 id_ALU_Control  in  4  ALU opcode.
REQ-012 id_shamt  in  5  shift amount.
REQ-013 id_imm  in  DATA_W  sign-extended immediate.
REQ-014 id_ALUSrc  in  1  1 = data2 takes immediate.
REQ-015 id_RegWrite  in  1  instruction writes rd.
REQ-016 exmem_RegWrite, memwb_RegWrite  in  1  later-stage write enables.
REQ-017 exmem_rd, memwb_rd  in  RA_W  later-stage destinations.
REQ-018 exmem_result, memwb_result  in  DATA_W  later-stage results.
REQ-019 data1, data2  out  DATA_W  ALU operands.
REQ-020 ALU_Control  out  4  registered opcode.
REQ-021 shamt  out  5  registered shift amount.
REQ-022 ex_valid, ex_RegWrite  out  1  EX valid; write enable gated by ex_valid.
REQ-023 ex_rd  out  RA_W  registered destination.
REQ-024 fwd_a, fwd_b  out  2  forward select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-025 ctrl_error  out  1  sticky illegal-opcode flag.

Function
REQ-026 Pipeline register SHALL capture all id_* fields on each rising edge when reset=0, flush=0, stall=0; one-cycle latency ID->EX.
REQ-027 stall=1 (flush=0): all stage registers SHALL hold.
REQ-028 flush=1 SHALL load a bubble regardless of stall: ex_valid=0, RegWrite=0, ALU_Control=4'b0010, shamt=0, addresses=0, data/imm=0, ALUSrc=0.
REQ-029 Priority: reset > flush > stall > load.
REQ-030 fwd_a SHALL be 10 if exmem_RegWrite && exmem_rd!=0 && exmem_rd==rs_q; else 01 if memwb_RegWrite && memwb_rd!=0 && memwb_rd==rs_q; else 00; fwd_b identical on rt_q.
REQ-031 Forwarding SHALL be combinational from registered addresses and current exmem/memwb inputs, so a stalled instruction sees updated forwarded values each cycle.
REQ-032 data1 SHALL be the fwd_a-selected value; data2 SHALL be imm_q if ALUSrc_q=1, else the fwd_b-selected value; fwd_b still reported when ALUSrc_q=1.
REQ-033 Register 0 SHALL never be forwarded.
REQ-034 Legal opcodes: 0000,0001,0010,0110,0111,1100,1101,1110; ctrl_error SHALL set one cycle after a load with id_valid=1 and an illegal id_ALU_Control, and remain set until reset.
REQ-035 Illegal opcode SHALL still be passed through unchanged on ALU_Control; bubbles never set ctrl_error.
REQ-036 ex_RegWrite SHALL equal RegWrite_q && ex_valid.

Reset
REQ-037 On reset all stage registers SHALL take bubble values (REQ-028) and ctrl_error=0; outputs valid from the first edge with reset=1.
REQ-038 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-039 Load: rs_data=5, rt_data=7, ALU_Control=0010, valid -> next cycle data1=5, data2=7, ex_valid=1, fwd_a=fwd_b=00.
REQ-040 Double hazard: rs=rt=3, exmem_rd=3 (result 0xAA), memwb_rd=3 (result 0xBB), both RegWrite -> data1=data2=0xAA, fwd=10.
REQ-041 Zero register: rs=0, exmem_rd=0, exmem_RegWrite=1, result 0xFF -> data1=rs_data, fwd_a=00.
REQ-042 Stall then flush same cycle: stall=1, flush=1 -> ex_valid=0, ALU_Control=0010, ex_RegWrite=0.
REQ-043 Illegal opcode 0011 valid -> ctrl_error=1 next cycle, stays 1 across 10 legal ops, clears only on reset.
REQ-044 ALUSrc=1, imm=0xFFFFFFFC, rt forwarded from MEM/WB -> data2=0xFFFFFFFC, fwd_b=01.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: pipeline register for decoded fields, EX/MEM and MEM/WB
// operand forwarding, and a sticky illegal-opcode flag.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [3:0]        id_ALU_Control,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_ALUSrc,
    input  logic              id_RegWrite,
    input  logic              exmem_RegWrite,
    input  logic              memwb_RegWrite,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [3:0]        ALU_Control,
    output logic [4:0]        shamt,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic [RA_W-1:0]   ex_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              ctrl_error
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned SH_W  = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [OP_W-1:0]  OP_ADD    = 4'b0010;
    localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b10;
    localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic [OP_W-1:0]   alu_ctrl;
        logic [SH_W-1:0]   shamt;
        logic [RA_W-1:0]   rs;
        logic [RA_W-1:0]   rt;
        logic [RA_W-1:0]   rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } stage_t;

    // A bubble is an ADD with everything else zeroed and no write-back.
    localparam stage_t BUBBLE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        alu_src:   1'b0,
        alu_ctrl:  OP_ADD,
        shamt:     '0,
        rs:        '0,
        rt:        '0,
        rd:        '0,
        rs_data:   '0,
        rt_data:   '0,
        imm:       '0
    };

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101, 4'b1110: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // EX/MEM wins over MEM/WB because it holds the younger write; r0 is never forwarded.
    function automatic logic [SEL_W-1:0] fwd_select(
        input logic [RA_W-1:0] src,
        input logic            em_we,
        input logic [RA_W-1:0] em_rd,
        input logic            mw_we,
        input logic [RA_W-1:0] mw_rd
    );
        logic [SEL_W-1:0] sel;
        sel = FWD_RF;
        if (em_we && (em_rd != '0) && (em_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_value(
        input logic [SEL_W-1:0]  sel,
        input logic [DATA_W-1:0] rf_val,
        input logic [DATA_W-1:0] em_val,
        input logic [DATA_W-1:0] mw_val
    );
        logic [DATA_W-1:0] val;
        case (sel)
            FWD_EXMEM: val = em_val;
            FWD_MEMWB: val = mw_val;
            default:   val = rf_val;
        endcase
        return val;
    endfunction

    stage_t stage_q;
    stage_t stage_d;
    logic   ctrl_error_q;
    logic   ctrl_error_d;
    logic   load_en;

    logic [SEL_W-1:0]  fwd_a_c;
    logic [SEL_W-1:0]  fwd_b_c;
    logic [DATA_W-1:0] rt_fwd_c;

    assign load_en = ~flush & ~stall;

    // Next-state: flush beats stall, stall beats load.
    always_comb begin
        stage_d      = stage_q;
        ctrl_error_d = ctrl_error_q;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (!stall) begin
            stage_d.valid     = id_valid;
            stage_d.reg_write = id_RegWrite;
            stage_d.alu_src   = id_ALUSrc;
            stage_d.alu_ctrl  = id_ALU_Control;
            stage_d.shamt     = id_shamt;
            stage_d.rs        = id_rs;
            stage_d.rt        = id_rt;
            stage_d.rd        = id_rd;
            stage_d.rs_data   = id_rs_data;
            stage_d.rt_data   = id_rt_data;
            stage_d.imm       = id_imm;
        end
        if (load_en && id_valid && !is_legal_op(id_ALU_Control)) begin
            ctrl_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q      <= BUBBLE;
            ctrl_error_q <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            ctrl_error_q <= ctrl_error_d;
        end
    end

    // Forwarding tracks the live EX/MEM and MEM/WB buses so a stalled op picks up new results.
    always_comb begin
        fwd_a_c  = fwd_select(stage_q.rs, exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd);
        fwd_b_c  = fwd_select(stage_q.rt, exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd);
        rt_fwd_c = fwd_value(fwd_b_c, stage_q.rt_data, exmem_result, memwb_result);
    end

    assign fwd_a       = fwd_a_c;
    assign fwd_b       = fwd_b_c;
    assign data1       = fwd_value(fwd_a_c, stage_q.rs_data, exmem_result, memwb_result);
    assign data2       = stage_q.alu_src ? stage_q.imm : rt_fwd_c;
    assign ALU_Control = stage_q.alu_ctrl;
    assign shamt       = stage_q.shamt;
    assign ex_valid    = stage_q.valid;
    assign ex_RegWrite = stage_q.reg_write & stage_q.valid;
    assign ex_rd       = stage_q.rd;
    assign ctrl_error  = ctrl_error_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a behavioural stage model checked every
// cycle on the falling edge, plus hand-computed literal expectations.
module tb_alu_operand_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [3:0]  id_ALU_Control;
    logic [4:0]  id_shamt;
    logic [31:0] id_imm;
    logic        id_ALUSrc;
    logic        id_RegWrite;
    logic        exmem_RegWrite;
    logic        memwb_RegWrite;
    logic [4:0]  exmem_rd;
    logic [4:0]  memwb_rd;
    logic [31:0] exmem_result;
    logic [31:0] memwb_result;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [3:0]  ALU_Control;
    logic [4:0]  shamt;
    logic        ex_valid;
    logic        ex_RegWrite;
    logic [4:0]  ex_rd;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        ctrl_error;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    alu_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_ALU_Control(id_ALU_Control), .id_shamt(id_shamt), .id_imm(id_imm),
        .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .exmem_RegWrite(exmem_RegWrite), .memwb_RegWrite(memwb_RegWrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .data1(data1), .data2(data2), .ALU_Control(ALU_Control), .shamt(shamt),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_rd(ex_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ctrl_error(ctrl_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the instruction currently sitting in EX.
    logic        m_valid, m_rw, m_alusrc, m_err;
    logic [3:0]  m_op;
    logic [4:0]  m_shamt, m_rs, m_rt, m_rd;
    logic [31:0] m_rsd, m_rtd, m_imm;

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_alusrc = 0; m_op = 4'b0010; m_shamt = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_bubble();
            m_err = 0;
        end else if (flush) begin
            model_bubble();
        end else if (!stall) begin
            m_valid = id_valid; m_rw = id_RegWrite; m_alusrc = id_ALUSrc;
            m_op = id_ALU_Control; m_shamt = id_shamt;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
            if (id_valid && !(id_ALU_Control inside
                {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110}))
                m_err = 1;
        end
    end

    function automatic logic [1:0] exp_sel(input logic [4:0] a);
        if (exmem_RegWrite && exmem_rd != 0 && exmem_rd == a) return 2'b10;
        if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == a) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_val(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b10) return exmem_result;
        if (sel == 2'b01) return memwb_result;
        return rf;
    endfunction

    logic [1:0] cmp_sa, cmp_sb;

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_sa = exp_sel(m_rs);
            cmp_sb = exp_sel(m_rt);
            check("cmp_data1", data1, exp_val(cmp_sa, m_rsd));
            check("cmp_data2", data2, m_alusrc ? m_imm : exp_val(cmp_sb, m_rtd));
            check("cmp_fwd_a", 32'(fwd_a), 32'(cmp_sa));
            check("cmp_fwd_b", 32'(fwd_b), 32'(cmp_sb));
            check("cmp_alu_ctrl", 32'(ALU_Control), 32'(m_op));
            check("cmp_shamt", 32'(shamt), 32'(m_shamt));
            check("cmp_ex_valid", 32'(ex_valid), 32'(m_valid));
            check("cmp_ex_regwrite", 32'(ex_RegWrite), 32'(m_rw && m_valid));
            check("cmp_ex_rd", 32'(ex_rd), 32'(m_rd));
            check("cmp_ctrl_error", 32'(ctrl_error), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [3:0] op, input logic [4:0] sh, input logic [31:0] imm,
                          input logic src, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_ALU_Control = op; id_shamt = sh; id_imm = imm; id_ALUSrc = src; id_RegWrite = rw;
    endtask

    task automatic set_fw(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_RegWrite = ew; exmem_rd = erd; exmem_result = eres;
        memwb_RegWrite = mw; memwb_rd = mrd; memwb_result = mres;
    endtask

    logic [3:0] legal_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                  4'b0111, 4'b1100, 4'b1101, 4'b1110};

    initial begin
        reset = 1; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        set_fw(0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1;
        tick();
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_alu_ctrl", 32'(ALU_Control), 32'h2);
        check("rst_ctrl_error", 32'(ctrl_error), 32'd0);
        check("rst_data1", data1, 32'd0);
        reset = 0;

        // Plain load, no hazards
        set_id(1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 4'b0010, 5'd3, 32'd0, 0, 1);
        tick();
        check("load_data1", data1, 32'd5);
        check("load_data2", data2, 32'd7);
        check("load_ex_valid", 32'(ex_valid), 32'd1);
        check("load_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        check("load_ex_rd", 32'(ex_rd), 32'd4);
        check("load_shamt", 32'(shamt), 32'd3);

        // Double hazard: EX/MEM wins
        set_id(1, 5'd3, 5'd3, 5'd6, 32'h11, 32'h22, 4'b0110, 0, 0, 0, 1);
        set_fw(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
        tick();
        check("dh_data1", data1, 32'hAA);
        check("dh_data2", data2, 32'hAA);
        check("dh_fwd_a", 32'(fwd_a), 32'h2);
        check("dh_fwd_b", 32'(fwd_b), 32'h2);

        // Stalled op sees forwarding change live
        stall = 1;
        set_id(1, 5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 4'b0000, 0, 0, 0, 1);
        exmem_RegWrite = 0;
        #1;
        check("stall_live_data1", data1, 32'hBB);
        check("stall_live_fwd_a", 32'(fwd_a), 32'h1);
        tick();
        check("stall_hold_rd", 32'(ex_rd), 32'd6);
        check("stall_hold_op", 32'(ALU_Control), 32'h6);
        stall = 0;

        // r0 never forwarded
        set_id(1, 5'd0, 5'd2, 5'd5, 32'h1234, 32'h8, 4'b0001, 0, 0, 0, 1);
        set_fw(1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE);
        tick();
        check("r0_data1", data1, 32'h1234);
        check("r0_fwd_a", 32'(fwd_a), 32'd0);

        // Stall and flush together give a bubble
        set_id(1, 5'd7, 5'd8, 5'd10, 32'h70, 32'h80, 4'b1100, 5'd2, 0, 0, 1);
        set_fw(0, 0, 0, 0, 0, 0);
        tick();
        check("pre_flush_valid", 32'(ex_valid), 32'd1);
        stall = 1; flush = 1;
        tick();
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        check("flush_alu_ctrl", 32'(ALU_Control), 32'h2);
        check("flush_ex_regwrite", 32'(ex_RegWrite), 32'd0);
        check("flush_ex_rd", 32'(ex_rd), 32'd0);
        stall = 0; flush = 0;

        // Immediate operand while rt is forwarded from MEM/WB
        set_id(1, 5'd1, 5'd9, 5'd2, 32'h3, 32'h4, 4'b0010, 0, 32'hFFFFFFFC, 1, 1);
        set_fw(1, 5'd12, 32'h55, 1, 5'd9, 32'h66);
        tick();
        check("imm_data2", data2, 32'hFFFFFFFC);
        check("imm_fwd_b", 32'(fwd_b), 32'h1);
        check("imm_data1", data1, 32'h3);
        set_fw(0, 0, 0, 0, 0, 0);

        // Invalid slot with illegal opcode: passthrough, no error, no write
        set_id(0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 4'b0011, 0, 0, 0, 1);
        tick();
        check("bub_ctrl_error", 32'(ctrl_error), 32'd0);
        check("bub_alu_ctrl", 32'(ALU_Control), 32'h3);
        check("bub_ex_regwrite", 32'(ex_RegWrite), 32'd0);

        // Valid illegal opcode sets sticky error
        set_id(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 4'b0011, 0, 0, 0, 1);
        tick();
        check("ill_ctrl_error", 32'(ctrl_error), 32'd1);
        check("ill_alu_ctrl", 32'(ALU_Control), 32'h3);
        for (int i = 0; i < 10; i++) begin
            set_id(1, 5'(i + 1), 5'(i + 2), 5'(i + 3), 32'(i * 3), 32'(i * 5),
                   legal_ops[i % 8], 5'(i), 32'(i), 1'(i % 2), 1);
            tick();
        end
        check("sticky_ctrl_error", 32'(ctrl_error), 32'd1);
        reset = 1;
        tick();
        check("clr_ctrl_error", 32'(ctrl_error), 32'd0);
        reset = 0;

        // Reset during stall discards held instruction
        set_id(1, 5'd4, 5'd5, 5'd6, 32'h44, 32'h55, 4'b0111, 5'd1, 0, 0, 1);
        tick();
        stall = 1;
        set_id(1, 5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 4'b0000, 0, 0, 0, 1);
        tick();
        check("stall_held_data1", data1, 32'h44);
        reset = 1;
        tick();
        check("rst_stall_valid", 32'(ex_valid), 32'd0);
        check("rst_stall_data1", data1, 32'd0);
        reset = 0; stall = 0;
        tick();
        check("post_rst_load_data1", data1, 32'h1);

        chk_en = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
